// File: rtl/tnn_prof_pkg.sv
// Shared definitions for the TNN node error profiler: operand width,
// sweep index width, controller states and the exact reference decision.
package tnn_prof_pkg;

    localparam int W     = 3;
    localparam int IDX_W = 3 * W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } prof_state_t;

    // Exact threshold decision a + b >= c, evaluated one bit wider than the
    // operands so the sum never wraps.
    function automatic logic exact_ge(input logic [W-1:0] a,
                                      input logic [W-1:0] b,
                                      input logic [W-1:0] c);
        logic [W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return (sum >= {1'b0, c});
    endfunction

endpackage

// File: rtl/tnn_prof_delay.sv
// DEPTH-stage shift register that lines up {valid, exact, idx} with the
// decision coming back from a pipelined node; a plain wire when DEPTH = 0.
module tnn_prof_delay #(
    parameter int DEPTH = 0,
    parameter int WIDTH = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_pass
            assign dout = din;
        end else begin : g_pipe
            logic [WIDTH-1:0] line_q [DEPTH];
            logic [WIDTH-1:0] line_d [DEPTH];

            // Next contents: new entry at stage 0, every other stage shifts by one.
            always_comb begin
                line_d[0] = din;
                for (int i = 1; i < DEPTH; i++) begin
                    line_d[i] = line_q[i-1];
                end
            end

            // Register the line; reset clears the valid tags along with the data.
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        line_q[i] <= '0;
                    end
                end else begin
                    line_q <= line_d;
                end
            end

            assign dout = line_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/tnn_node_error_profiler.sv
// Sweeps every operand triple into an approximate TNN threshold node, aligns
// the returned decision with the exact one and records the mismatch count and
// the index of the first mismatch.
module tnn_node_error_profiler
    import tnn_prof_pkg::*;
#(
    parameter int DUT_LAT = 0,
    parameter int CNT_W   = 3 * W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [W-1:0]     op_a,
    output logic [W-1:0]     op_b,
    output logic [W-1:0]     op_c,
    output logic             op_valid,
    input  logic             ax_in,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] err_count,
    output logic             first_err_valid,
    output logic [IDX_W-1:0] first_err_idx
);

    localparam int                 DLY_W   = IDX_W + 2;
    localparam logic [IDX_W-1:0]   IDX_MAX = '1;

    prof_state_t      state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             op_valid_q, op_valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] err_count_q, err_count_d;
    logic             fev_q, fev_d;
    logic [IDX_W-1:0] fei_q, fei_d;
    logic [1:0]       drain_q, drain_d;

    logic [DLY_W-1:0] dly_in, dly_out;
    logic             dly_vld, dly_exact;
    logic [IDX_W-1:0] dly_idx;

    assign dly_in = {op_valid_q, exact_ge(idx_q[IDX_W-1:2*W], idx_q[2*W-1:W], idx_q[W-1:0]), idx_q};

    tnn_prof_delay #(
        .DEPTH (DUT_LAT),
        .WIDTH (DLY_W)
    ) u_delay (
        .clk  (clk),
        .rst  (rst),
        .din  (dly_in),
        .dout (dly_out)
    );

    assign {dly_vld, dly_exact, dly_idx} = dly_out;

    // Result accumulation from the aligned stream, then the sweep controller.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        op_valid_d  = op_valid_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        err_count_d = err_count_q;
        fev_d       = fev_q;
        fei_d       = fei_q;
        drain_d     = drain_q;

        if (dly_vld && (ax_in != dly_exact)) begin
            err_count_d = err_count_q + CNT_W'(1);
            if (!fev_q) begin
                fev_d = 1'b1;
                fei_d = dly_idx;
            end
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    err_count_d = '0;
                    fev_d       = 1'b0;
                    fei_d       = '0;
                    idx_d       = '0;
                    op_valid_d  = 1'b1;
                    busy_d      = 1'b1;
                    state_d     = RUN;
                end
            end
            RUN: begin
                if (idx_q == IDX_MAX) begin
                    op_valid_d = 1'b0;
                    if (DUT_LAT == 0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = DRAIN;
                        drain_d = 2'(DUT_LAT);
                    end
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            DRAIN: begin
                if (drain_q == 2'd1) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    drain_d = drain_q - 2'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset returns everything to zero / IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            op_valid_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_count_q <= '0;
            fev_q       <= 1'b0;
            fei_q       <= '0;
            drain_q     <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            op_valid_q  <= op_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_count_q <= err_count_d;
            fev_q       <= fev_d;
            fei_q       <= fei_d;
            drain_q     <= drain_d;
        end
    end

    assign op_a            = idx_q[IDX_W-1:2*W];
    assign op_b            = idx_q[2*W-1:W];
    assign op_c            = idx_q[W-1:0];
    assign op_valid        = op_valid_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign err_count       = err_count_q;
    assign first_err_valid = fev_q;
    assign first_err_idx   = fei_q;

endmodule

// File: tb/tb_tnn_node_error_profiler.sv
// Bench for the TNN node error profiler: two instances (combinational node and
// a 2-stage registered node), a sweep-level behavioural model and literal pins.
module tb_tnn_node_error_profiler;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    always #5 clk = ~clk;

    logic [2:0] a0, b0, c0, a2, b2, c2;
    logic       ov0, ov2, ax0, ax2, bz0, bz2, dn0, dn2, fv0, fv2;
    logic [9:0] e0, e2;
    logic [8:0] fi0, fi2;
    logic       p1, p2;

    int  mode = 0;
    bit  flip [512];
    int  checks = 0;
    int  failures = 0;
    int  cyc = 0;
    int  lat [2] = '{0, 2};
    int  s [2] = '{-1000, -1000};
    bit  act [2] = '{0, 0};
    bit  have [2] = '{0, 0};
    int  perr [2] = '{0, 0};
    int  pfi [2] = '{0, 0};
    bit  pfv [2] = '{0, 0};
    int  ovc [2] = '{0, 0};

    tnn_node_error_profiler #(.DUT_LAT(0)) u0 (
        .clk(clk), .rst(rst), .start(start), .op_a(a0), .op_b(b0), .op_c(c0),
        .op_valid(ov0), .ax_in(ax0), .busy(bz0), .done(dn0), .err_count(e0),
        .first_err_valid(fv0), .first_err_idx(fi0));

    tnn_node_error_profiler #(.DUT_LAT(2)) u2 (
        .clk(clk), .rst(rst), .start(start), .op_a(a2), .op_b(b2), .op_c(c2),
        .op_valid(ov2), .ax_in(ax2), .busy(bz2), .done(dn2), .err_count(e2),
        .first_err_valid(fv2), .first_err_idx(fi2));

    function automatic bit exact_i(input int k);
        int a, b, c;
        a = k / 64;
        b = (k / 8) % 8;
        c = k % 8;
        return (a + b >= c);
    endfunction

    function automatic bit node_f(input int k, input int m);
        case (m)
            0:       return exact_i(k);
            1:       return 1'b0;
            2:       return 1'b1;
            3:       return exact_i(k) ^ (k == 300);
            default: return exact_i(k) ^ flip[k];
        endcase
    endfunction

    function automatic int count_err(input int m);
        int n = 0;
        for (int k = 0; k < 512; k++) if (node_f(k, m) != exact_i(k)) n++;
        return n;
    endfunction

    function automatic int first_err(input int m);
        for (int k = 0; k < 512; k++) if (node_f(k, m) != exact_i(k)) return k;
        return 0;
    endfunction

    // Nodes under test: combinational and a 2-stage registered wrapper.
    always_comb ax0 = node_f(int'({a0, b0, c0}), mode);
    always @(posedge clk) begin
        p1 <= node_f(int'({a2, b2, c2}), mode);
        p2 <= p1;
    end
    assign ax2 = p2;

    // Sweep-level model: records launch cycle and the expected sweep results.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                act[i]  <= 1'b0;
                have[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (start && (!act[i] || cyc >= s[i] + 514 + lat[i])) begin
                    act[i]  <= 1'b1;
                    have[i] <= 1'b1;
                    s[i]    <= cyc;
                    perr[i] <= count_err(mode);
                    pfi[i]  <= first_err(mode);
                    pfv[i]  <= (count_err(mode) != 0);
                end
            end
        end
        cyc <= cyc + 1;
    end

    task automatic chk(input string nm, input int i, input logic [31:0] actual, input logic [31:0] req);
        checks++;
        if (actual !== req) begin
            failures++;
            $display("FAIL %s u%0d cyc=%0d actual=%0d required=%0d", nm, i, cyc, actual, req);
        end
    endtask

    task automatic cmp(input int i, input logic bz, input logic dn, input logic ov,
                       input int idx, input int err, input logic fv, input int fi);
        int  n;
        bit  in_run, is_done, ev;
        n       = cyc;
        in_run  = act[i] && (n >= s[i] + 1) && (n <= s[i] + 512 + lat[i]);
        is_done = act[i] && (n == s[i] + 513 + lat[i]);
        ev      = in_run && (n <= s[i] + 512);
        chk("busy", i, bz, in_run);
        chk("done", i, dn, is_done);
        chk("op_valid", i, ov, ev);
        if (ev) chk("op_idx", i, idx, n - s[i] - 1);
        if (!in_run) begin
            chk("err_count", i, err, have[i] ? perr[i] : 0);
            chk("first_err_valid", i, fv, have[i] ? pfv[i] : 0);
            chk("first_err_idx", i, fi, have[i] ? pfi[i] : 0);
        end
        if (rst) ovc[i] = 0;
        else if (ov) ovc[i]++;
        if (is_done) begin
            chk("op_valid_cycles", i, ovc[i], 512);
            ovc[i] = 0;
        end
    endtask

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        cmp(0, bz0, dn0, ov0, int'({a0, b0, c0}), int'(e0), fv0, int'(fi0));
        cmp(1, bz2, dn2, ov2, int'({a2, b2, c2}), int'(e2), fv2, int'(fi2));
    end

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_done2(input int budget);
        int k;
        for (k = 0; k < budget; k++) begin
            @(negedge clk);
            if (dn2) break;
        end
        if (k == budget) begin
            checks++;
            failures++;
            $display("FAIL done_timeout actual=no_done required=done_within_%0d", budget);
        end
    endtask

    int e_first;

    initial begin
        for (int k = 0; k < 512; k++) flip[k] = ($urandom_range(0, 15) == 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_op_a", 0, a0, 0);
        chk("reset_err", 1, e2, 0);

        // Exact node.
        mode = 0;
        pulse_start();
        wait_done2(700);
        chk("exact_err", 0, e0, 0);
        chk("exact_fv", 0, fv0, 0);
        chk("exact_err", 1, e2, 0);

        // Constant 0 node.
        @(posedge clk); #1 mode = 1;
        pulse_start();
        wait_done2(700);
        chk("c0_err", 0, e0, 428);
        chk("c0_fi", 0, fi0, 0);
        chk("c0_fv", 0, fv0, 1);
        chk("c0_err", 1, e2, 428);

        // Constant 1 node.
        @(posedge clk); #1 mode = 2;
        pulse_start();
        wait_done2(700);
        chk("c1_err", 0, e0, 84);
        chk("c1_fi", 0, fi0, 1);
        chk("c1_fi", 1, fi2, 1);

        // Single inverted output at idx 300, with a start pulse while busy.
        @(posedge clk); #1 mode = 3;
        pulse_start();
        repeat (50) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_done2(700);
        chk("inv_err", 1, e2, 1);
        chk("inv_fi", 1, fi2, 300);
        chk("inv_fv", 1, fv2, 1);

        // Reset 100 cycles into a randomized sweep, then a full sweep.
        @(posedge clk); #1 mode = 4;
        pulse_start();
        repeat (99) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", 0, bz0, 0);
        chk("rst_op_valid", 1, ov2, 0);
        chk("rst_err", 1, e2, 0);
        pulse_start();
        wait_done2(700);
        chk("rand_err", 1, e2, count_err(4));

        // Back-to-back sweeps with start held high.
        @(posedge clk); #1 start = 1'b1;
        wait_done2(700);
        e_first = int'(e2);
        wait_done2(700);
        chk("b2b_same_err", 1, e2, e_first);
        @(posedge clk); #1 start = 1'b0;
        repeat (600) @(posedge clk);
        @(negedge clk);
        chk("final_idle_busy", 0, bz0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
